// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of a single-port neighbour-table memory.
// A grant covers one whole client transaction (start pulse -> done); a watchdog
// forces release when the owner never raises done.
// Ports:
//   i_clock, i_nrst       clock, synchronous active-low reset
//   i_req                 level request per client
//   o_cl_start            one-cycle start pulse to the newly granted client
//   i_cl_done             client done levels (only the owner's, only in RUN)
//   i_cl_addr/_wr_en/_wdata  packed client memory requests
//   o_cl_rdata_c          memory read data broadcast to all clients
//   o_mem_addr_c/_wr_en_c/_wdata_c  memory request of the current owner
//   i_mem_rdata           memory read data
//   o_grant               one-hot current owner, 0 when idle
//   o_busy                high in START/RUN/RELEASE
//   o_timeout_err         sticky watchdog flag
//   o_err_id              client index of the most recent watchdog release
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                         i_clock,
  input  logic                         i_nrst,
  input  logic [NUM_REQ-1:0]           i_req,
  output logic [NUM_REQ-1:0]           o_cl_start,
  input  logic [NUM_REQ-1:0]           i_cl_done,
  input  logic [NUM_REQ*ADDR_W-1:0]    i_cl_addr,
  input  logic [NUM_REQ-1:0]           i_cl_wr_en,
  input  logic [NUM_REQ*DATA_W-1:0]    i_cl_wdata,
  output logic [DATA_W-1:0]            o_cl_rdata_c,
  output logic [ADDR_W-1:0]            o_mem_addr_c,
  output logic                         o_mem_wr_en_c,
  output logic [DATA_W-1:0]            o_mem_wdata_c,
  input  logic [DATA_W-1:0]            i_mem_rdata,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic                         o_busy,
  output logic                         o_timeout_err,
  output logic [$clog2(NUM_REQ)-1:0]   o_err_id
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_RUN     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0] r_start, w_start_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_terr, w_terr_nxt;
  logic [IDX_W-1:0]   r_err_id, w_err_id_nxt;
  logic [IDX_W-1:0]   r_rr, w_rr_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [WD_W-1:0]    r_wd, w_wd_nxt;

  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic [IDX_W-1:0]   w_scan_idx;
  int unsigned        w_scan;
  logic [NUM_REQ-1:0] w_win_onehot;
  logic [IDX_W-1:0]   w_rr_after;
  logic [WD_W-1:0]    w_wd_inc;

  // Round-robin search: first requesting client at or after r_rr.
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_scan     = 0;
    w_scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_scan = 32'(r_rr) + k;
      if (w_scan >= NUM_REQ) w_scan = w_scan - NUM_REQ;
      w_scan_idx = IDX_W'(w_scan);
      if (!w_found && i_req[w_scan_idx]) begin
        w_found = 1'b1;
        w_win   = w_scan_idx;
      end
    end
  end

  assign w_win_onehot = NUM_REQ'(1) << w_win;
  assign w_rr_after   = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
  // Watchdog counter saturates instead of wrapping.
  assign w_wd_inc     = (r_wd == '1) ? r_wd : r_wd + WD_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_start_nxt  = '0;
    w_busy_nxt   = r_busy;
    w_terr_nxt   = r_terr;
    w_err_id_nxt = r_err_id;
    w_rr_nxt     = r_rr;
    w_owner_nxt  = r_owner;
    w_wd_nxt     = r_wd;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_START;
          w_grant_nxt = w_win_onehot;
          w_start_nxt = w_win_onehot;
          w_busy_nxt  = 1'b1;
          w_owner_nxt = w_win;
        end
      end
      S_START: begin
        w_state_nxt = S_RUN;
        w_wd_nxt    = '0;
      end
      S_RUN: begin
        w_wd_nxt = w_wd_inc;
        // Done beats a simultaneous watchdog expiry.
        if (i_cl_done[r_owner]) begin
          w_state_nxt = S_RELEASE;
          w_grant_nxt = '0;
        end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
          w_state_nxt  = S_RELEASE;
          w_grant_nxt  = '0;
          w_terr_nxt   = 1'b1;
          w_err_id_nxt = r_owner;
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_rr_nxt    = w_rr_after;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clock) begin
    if (!i_nrst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_start  <= '0;
      r_busy   <= 1'b0;
      r_terr   <= 1'b0;
      r_err_id <= '0;
      r_rr     <= '0;
      r_owner  <= '0;
      r_wd     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_start  <= w_start_nxt;
      r_busy   <= w_busy_nxt;
      r_terr   <= w_terr_nxt;
      r_err_id <= w_err_id_nxt;
      r_rr     <= w_rr_nxt;
      r_owner  <= w_owner_nxt;
      r_wd     <= w_wd_nxt;
    end
  end

  // AND-OR mux from the one-hot grant; everything reads zero while idle.
  always_comb begin
    o_mem_addr_c  = '0;
    o_mem_wdata_c = '0;
    o_mem_wr_en_c = 1'b0;
    for (int unsigned n = 0; n < NUM_REQ; n++) begin
      if (r_grant[n]) begin
        o_mem_addr_c  = o_mem_addr_c  | i_cl_addr[n*ADDR_W +: ADDR_W];
        o_mem_wdata_c = o_mem_wdata_c | i_cl_wdata[n*DATA_W +: DATA_W];
        o_mem_wr_en_c = o_mem_wr_en_c | i_cl_wr_en[n];
      end
    end
  end

  assign o_cl_rdata_c  = i_mem_rdata;
  assign o_grant       = r_grant;
  assign o_cl_start    = r_start;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_terr;
  assign o_err_id      = r_err_id;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: reactive client drivers, a transaction-level
// round-robin model feeding an expectation queue, and a negedge monitor.
module tb_mem_port_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 16;

  logic              clk = 1'b0;
  logic              nrst;
  logic [NR-1:0]     req;
  logic [NR-1:0]     cl_start;
  logic [NR-1:0]     cl_done;
  logic [NR*AW-1:0]  cl_addr;
  logic [NR-1:0]     cl_wr_en;
  logic [NR*DW-1:0]  cl_wdata;
  logic [DW-1:0]     cl_rdata;
  logic [AW-1:0]     mem_addr;
  logic              mem_wr_en;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic [NR-1:0]     grant;
  logic              busy;
  logic              timeout_err;
  logic [1:0]        err_id;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_clock(clk), .i_nrst(nrst), .i_req(req), .o_cl_start(cl_start),
    .i_cl_done(cl_done), .i_cl_addr(cl_addr), .i_cl_wr_en(cl_wr_en),
    .i_cl_wdata(cl_wdata), .o_cl_rdata_c(cl_rdata), .o_mem_addr_c(mem_addr),
    .o_mem_wr_en_c(mem_wr_en), .o_mem_wdata_c(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_grant(grant), .o_busy(busy), .o_timeout_err(timeout_err), .o_err_id(err_id)
  );

  typedef struct {
    int w;
    int len;
    bit to;
  } item_t;

  item_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;
  bit    exp_terr = 1'b0;
  int    exp_err_id = 0;
  int    mon_st = 0;   // 0 wait, 1 owned, 2 idle gap, 3 grant due next cycle
  int    dd[NR];       // hold time per client for its next grant
  int    cdn[NR];      // cycles until the client raises done
  int    rr_model = 0;
  int    n_left = 0;
  int    dir_idx = 0;
  logic [NR-1:0] dmask [8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h1, 4'h4, 4'hC};
  int            dhold [8] = '{5, 5, 5, 5, 5, 3, 200, 4};

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_winner(input logic [NR-1:0] m, input int ptr);
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (ptr + k) % NR;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  // Model one grant: round-robin winner, grant length and watchdog outcome.
  task automatic push(input logic [NR-1:0] m, input int d);
    item_t it;
    it.w  = pick_winner(m, rr_model);
    it.to = (d > TO);
    it.len = it.to ? TO + 1 : d + 1;
    dd[it.w] = d;
    exp_q.push_back(it);
    rr_model = (it.w + 1) % NR;
    req = m;
  endtask

  task automatic next_item();
    int r;
    if (n_left == 0) begin
      req = '0;
    end else begin
      n_left--;
      if (dir_idx < 8) begin
        push(dmask[dir_idx], dhold[dir_idx]);
        dir_idx++;
      end else begin
        r = $urandom_range(0, 9);
        push(NR'($urandom_range(1, 15)),
             (r < 6) ? $urandom_range(1, 8) : (r == 6) ? 15 : (r == 7) ? 16 : (r == 8) ? 17 : 200);
      end
    end
  endtask

  // One clock of client behaviour, driven just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cl_addr   = {$urandom, $urandom};
    cl_wdata  = {$urandom, $urandom};
    cl_wr_en  = NR'($urandom);
    mem_rdata = DW'($urandom);
    for (int n = 0; n < NR; n++)
      if ($urandom_range(0, 3) == 0) cl_addr[n*AW +: AW] = 16'h068C;
    for (int n = 0; n < NR; n++) begin
      if (cdn[n] > 0) begin
        cdn[n]--;
        if (cdn[n] == 0) cl_done[n] = 1'b1;
      end else if (!grant[n] && $urandom_range(0, 7) == 0) begin
        cl_done[n] = ~cl_done[n];
      end
    end
    if (cl_start != '0) begin
      for (int n = 0; n < NR; n++)
        if (cl_start[n]) begin
          cl_done[n] = 1'b0;
          cdn[n] = dd[n];
        end
      next_item();
    end
  endtask

  task automatic drain();
    bit quiet;
    quiet = 1'b0;
    for (int i = 0; i < 3000 && !quiet; i++) begin
      step();
      quiet = (exp_q.size() == 0) && (mon_st == 0) && !busy && (req == '0);
    end
    if (!quiet) chk("drain_timeout", 0, 1);
  endtask

  // Monitor: pops one expectation per grant and follows it cycle by cycle.
  item_t cur;
  int    cnt = 0;
  int    wait_cyc = 0;
  int    owner;
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        mon_st = 0;
        wait_cyc = 0;
      end else begin
        owner = -1;
        case (mon_st)
          0, 3: begin
            if (grant != '0) begin
              wait_cyc = 0;
              if (exp_q.size() == 0) begin
                chk("unexpected_grant", grant, 0);
              end else begin
                cur = exp_q.pop_front();
                chk("grant_onehot", grant, 1 << cur.w);
                chk("start_pulse", cl_start, 1 << cur.w);
                chk("busy_start", busy, 1);
                owner = cur.w;
                cnt = 1;
                mon_st = 1;
              end
            end else if (mon_st == 3) begin
              chk("grant_after_gap", grant, 1 << exp_q[0].w);
              mon_st = 0;
            end else begin
              chk("busy_idle", busy, 0);
              wait_cyc++;
              if (exp_q.size() > 0 && wait_cyc > 50) begin
                chk("grant_wait_timeout", 0, 1);
                void'(exp_q.pop_front());
                wait_cyc = 0;
              end
            end
          end
          1: begin
            if (cnt < cur.len) begin
              chk("grant_hold", grant, 1 << cur.w);
              chk("start_low", cl_start, 0);
              chk("busy_run", busy, 1);
              owner = cur.w;
              cnt++;
            end else begin
              chk("grant_release", grant, 0);
              chk("busy_release", busy, 1);
              if (cur.to) begin
                exp_terr = 1'b1;
                exp_err_id = cur.w;
              end
              mon_st = 2;
            end
          end
          default: begin
            chk("grant_gap", grant, 0);
            chk("busy_gap", busy, 0);
            mon_st = (exp_q.size() > 0) ? 3 : 0;
          end
        endcase
        chk("timeout_err", timeout_err, exp_terr);
        chk("err_id", err_id, exp_err_id);
        chk("rdata_bcast", cl_rdata, mem_rdata);
        if (owner >= 0) begin
          chk("mem_addr", mem_addr, cl_addr[owner*AW +: AW]);
          chk("mem_wdata", mem_wdata, cl_wdata[owner*DW +: DW]);
          chk("mem_wr_en", mem_wr_en, cl_wr_en[owner]);
        end else begin
          chk("mem_addr_idle", mem_addr, 0);
          chk("mem_wdata_idle", mem_wdata, 0);
          chk("mem_wr_en_idle", mem_wr_en, 0);
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_start"}, cl_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_terr"}, timeout_err, 0);
    chk({tag, "_err_id"}, err_id, 0);
    chk({tag, "_mem_wr_en"}, mem_wr_en, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
  endtask

  initial begin
    nrst = 1'b0;
    req = '0;
    cl_done = 4'b0010;   // client 1 starts with a stale done level
    cl_addr = '0;
    cl_wr_en = '0;
    cl_wdata = '0;
    mem_rdata = '0;
    for (int n = 0; n < NR; n++) begin
      dd[n] = 1;
      cdn[n] = 0;
    end
    repeat (3) step();
    @(negedge clk);
    check_reset_state("reset");

    // Directed round-robin, single client and timeout cases, then random grants.
    step();
    nrst = 1'b1;
    mon_en = 1'b1;
    n_left = 48;
    dir_idx = 0;
    next_item();
    drain();

    // Reset while client 2 is in RUN; afterwards the lowest requester wins.
    n_left = 0;
    push(4'h4, 200);
    for (int i = 0; i < 60 && grant == '0; i++) step();
    chk("reset_test_grant", grant, 4'h4);
    repeat (5) step();
    mon_en = 1'b0;
    nrst = 1'b0;
    step();
    @(negedge clk);
    check_reset_state("mid_run_reset");
    exp_q.delete();
    rr_model = 0;
    exp_terr = 1'b0;
    exp_err_id = 0;
    push(4'hA, 4);
    nrst = 1'b1;
    mon_en = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
